// File: rtl/axis_power_accumulator_if.sv
// AXI-Stream style channel used by axis_power_accumulator for input, config and output.
// Handshake: a beat transfers on a rising clk edge where valid && ready (exposed as ok);
// the master holds data/last stable and keeps valid high until that transfer happens.
interface Axis_If #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ok;

  assign ok = valid & ready;

  modport master (
    output valid, data, last,
    input  ready, ok
  );

  modport slave (
    input  valid, data, last, ok,
    output ready
  );
endinterface

// File: rtl/axis_power_accumulator.sv
// Sums all lanes of 2^N accepted squared-sample beats into one output beat, N set at runtime.
// Optional macro AXIS_POWER_ACCUMULATOR_LAST_FLUSH_EN: data_in.last closes a window early.
module axis_power_accumulator #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 2,
  parameter int MAX_WINDOW_LOG2  = 8
) (
  input  logic   clk,
  input  logic   reset,
  Axis_If.slave  data_in,
  Axis_If.slave  config_in,
  Axis_If.master data_out
);
  localparam int OUT_WIDTH = SAMPLE_WIDTH + $clog2(PARALLEL_SAMPLES) + MAX_WINDOW_LOG2;
  localparam int CFG_WIDTH = $clog2(MAX_WINDOW_LOG2 + 1);
  localparam int CNT_WIDTH = MAX_WINDOW_LOG2 + 1;

  logic [OUT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CFG_WIDTH-1:0] r_active_log2;
  logic [CFG_WIDTH-1:0] r_pending_log2;
  logic                 r_pending_flag;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;

  logic [OUT_WIDTH-1:0] w_lane_sum;
  logic [CNT_WIDTH-1:0] w_win_max;
  logic [CFG_WIDTH-1:0] w_cfg_clamped;
  logic                 w_close;
  logic                 w_flush;
  logic                 w_apply;

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
      w_lane_sum = w_lane_sum + OUT_WIDTH'(data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end
  end

  assign w_win_max     = (CNT_WIDTH'(1) << r_active_log2) - CNT_WIDTH'(1);
  assign w_cfg_clamped = (config_in.data > CFG_WIDTH'(MAX_WINDOW_LOG2)) ?
                         CFG_WIDTH'(MAX_WINDOW_LOG2) : config_in.data;

`ifdef AXIS_POWER_ACCUMULATOR_LAST_FLUSH_EN
  assign w_flush = data_in.last;
`else
  assign w_flush = 1'b0;
`endif

  assign w_close = (r_beat_cnt == w_win_max) || w_flush;

  // Windows are only retimed on a boundary with no beat in flight.
  assign w_apply = r_pending_flag && (r_beat_cnt == '0) && !data_in.ok;

  assign data_in.ready   = !r_out_valid || data_out.ready;
  assign config_in.ready = 1'b1;
  assign data_out.valid  = r_out_valid;
  assign data_out.data   = r_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc          <= '0;
      r_beat_cnt     <= '0;
      r_active_log2  <= '0;
      r_pending_log2 <= '0;
      r_pending_flag <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
    end else begin
      if (data_in.ok) begin
        if (w_close) begin
          r_acc      <= '0;
          r_beat_cnt <= '0;
        end else begin
          r_acc      <= r_acc + w_lane_sum;
          r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
      end
      if (data_out.ok) begin
        r_out_valid <= 1'b0;
      end
      // A close in the same cycle as an output transfer reloads and keeps valid high.
      if (data_in.ok && w_close) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_acc + w_lane_sum;
      end
      if (w_apply) begin
        r_active_log2  <= r_pending_log2;
        r_pending_flag <= 1'b0;
      end
      if (config_in.ok) begin
        r_pending_log2 <= w_cfg_clamped;
        r_pending_flag <= 1'b1;
      end
    end
  end

`ifdef AXIS_POWER_ACCUMULATOR_LAST_FLUSH_EN
  logic r_out_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_last <= 1'b0;
    end else if (data_in.ok && w_close) begin
      r_out_last <= data_in.last;
    end
  end

  assign data_out.last = r_out_last;
`else
  assign data_out.last = 1'b0;
`endif

endmodule

// File: tb/tb_axis_power_accumulator.sv
// Directed bench for axis_power_accumulator: scoreboard queue of expected window sums,
// checked whenever an output beat transfers.
module tb_axis_power_accumulator;
  localparam int SW  = 16;
  localparam int PS  = 2;
  localparam int MW  = 8;
  localparam int OW  = SW + $clog2(PS) + MW;
  localparam int CW  = $clog2(MW + 1);
  localparam int W   = OW + 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic rand_mode;
  logic [W-1:0] exp_q[$];

  Axis_If #(.DATA_WIDTH(SW*PS)) in_if ();
  Axis_If #(.DATA_WIDTH(CW))    cfg_if ();
  Axis_If #(.DATA_WIDTH(OW))    out_if ();

  axis_power_accumulator #(
    .SAMPLE_WIDTH(SW), .PARALLEL_SAMPLES(PS), .MAX_WINDOW_LOG2(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .data_in(in_if.slave), .config_in(cfg_if.slave), .data_out(out_if.master)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0;
    cfg_if.valid = 1'b0; cfg_if.data = '0; cfg_if.last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drivers
  task automatic send_beat(input logic [SW-1:0] l0, input logic [SW-1:0] l1, input logic lst);
    logic hs;
    int   n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = {l1, l0};
    in_if.last  = lst;
    do begin
      @(negedge clk);
      hs = in_if.ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 2000);
    if (!hs) check("in_handshake_timeout", 64'(hs), 64'd1);
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  // Writes N, then leaves one idle cycle so a boundary apply can happen.
  task automatic send_cfg(input logic [CW-1:0] n_val);
    logic hs;
    cfg_if.valid = 1'b1;
    cfg_if.data  = n_val;
    @(negedge clk);
    hs = cfg_if.ready;
    check("cfg_ready", 64'(hs), 64'd1);
    @(posedge clk);
    #1 cfg_if.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [OW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: compare every output transfer, and the input backpressure rule
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("in_ready_rule", 64'(in_if.ready), 64'(!(out_if.valid && !out_if.ready)));
        if (out_if.valid && out_if.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_output observed=%0h expected=none", out_if.data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_if.data), 64'(e[OW-1:0]));
            check("out_last", 64'(out_if.last), 64'(e[OW]));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_if.ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rand_mode = 1'b0;
    out_if.ready = 1'b1;
    out_if.last  = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_out_data",  64'(out_if.data),  64'd0);
    check("rst_out_last",  64'(out_if.last),  64'd0);
    check("rst_in_ready",  64'(in_if.ready),  64'd1);
    check("rst_cfg_ready", 64'(cfg_if.ready), 64'd1);
    @(posedge clk);
    #1;

    // N=0: one output per beat, one cycle latency
    for (int i = 0; i < 4; i++) push_exp(OW'(24'h1800), 1'b0);
    send_beat(16'h1000, 16'h0800, 1'b0);
    check("n0_latency_valid", 64'(out_if.valid), 64'd1);
    check("n0_latency_data",  64'(out_if.data),  64'h1800);
    for (int i = 0; i < 3; i++) send_beat(16'h1000, 16'h0800, 1'b0);
    wait_drain();

    // N=2, then the same windows under random backpressure
    send_cfg(CW'(2));
    push_exp(OW'(32'h20000), 1'b0);
    for (int i = 0; i < 4; i++) send_beat(16'h4000, 16'h4000, 1'b0);
    wait_drain();
    rand_mode = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(OW'(32'h20000), 1'b0);
    for (int i = 0; i < 12; i++) send_beat(16'h4000, 16'h4000, 1'b0);
    wait_drain();
    rand_mode = 1'b0;
    #20 out_if.ready = 1'b1;
    @(posedge clk);
    #1;

    // N=8 full-scale, then N=15 clamps to 8
    send_cfg(CW'(8));
    push_exp(OW'(32'h1FFFE00), 1'b0);
    for (int i = 0; i < 256; i++) send_beat(16'hFFFF, 16'hFFFF, 1'b0);
    wait_drain();
    send_cfg(CW'(15));
    push_exp(OW'(32'h200), 1'b0);
    for (int i = 0; i < 256; i++) send_beat(16'h0001, 16'h0001, 1'b0);
    wait_drain();

    // Config written mid-window does not retime the open window
    send_cfg(CW'(2));
    push_exp(OW'(12), 1'b0);
    push_exp(OW'(6), 1'b0);
    push_exp(OW'(6), 1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'd1, 16'd2, 1'b0);
    send_cfg(CW'(1));
    send_beat(16'd1, 16'd2, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_beat(16'd1, 16'd2, 1'b0);
    wait_drain();

    // last on the 5th beat of an N=3 window
    send_cfg(CW'(3));
`ifdef AXIS_POWER_ACCUMULATOR_LAST_FLUSH_EN
    push_exp(OW'(10), 1'b1);
    push_exp(OW'(16), 1'b0);
`else
    push_exp(OW'(16), 1'b0);
`endif
    for (int i = 0; i < 13; i++) send_beat(16'd1, 16'd1, (i == 4));
    wait_drain();

    // Reset mid-window discards partial sum and pending config; N returns to 0
    send_beat(16'd5, 16'd5, 1'b0);
    send_cfg(CW'(3));
    send_beat(16'd5, 16'd5, 1'b0);
    do_reset();
    #1;
    check("post_reset_valid", 64'(out_if.valid), 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    push_exp(OW'(7), 1'b0);
    push_exp(OW'(7), 1'b0);
    send_beat(16'd7, 16'd0, 1'b0);
    send_beat(16'd3, 16'd4, 1'b0);
    wait_drain();
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
